// File: rtl/ky32_arb_pkg.sv
// ky32_arb_pkg: shared state encoding and sizing constants for the ky32 bus arbiter.
package ky32_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  localparam int NREQ = 4;
  localparam int SELW = 2;
  localparam int LOCK_MAX = 4;
endpackage

// File: rtl/KY32_mux4x32.sv
// KY32_mux4x32: 4:1 32-bit word multiplexer.
module KY32_mux4x32 (
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] a3,
  input  logic [1:0]  s,
  output logic [31:0] y
);
  assign y = s[1] ? (s[0] ? a3 : a2) : (s[0] ? a1 : a0);
endmodule

// File: rtl/ky32_bus_arbiter.sv
// ky32_bus_arbiter: 4-way round-robin arbiter sharing one 32-bit slave port with valid/ready and timeout.
// Define KY32_ARB_LOCK_EN to add the lock port for locked bursts of up to LOCK_MAX transfers.
module ky32_bus_arbiter import ky32_arb_pkg::*; #(
  parameter int TIMEOUT = 16,
  parameter int CW = 5
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [NREQ-1:0] req,
  input  logic [31:0]     d0,
  input  logic [31:0]     d1,
  input  logic [31:0]     d2,
  input  logic [31:0]     d3,
  output logic [31:0]     bus_data,
  output logic [SELW-1:0] bus_sel,
  output logic [NREQ-1:0] gnt,
  output logic            bus_valid,
  input  logic            bus_ready,
  output logic [NREQ-1:0] ack,
  output logic            err
`ifdef KY32_ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0] lock
`endif
);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  state_t          state;
  logic [SELW-1:0] ptr, win;
  logic [CW-1:0]   cnt;
`ifdef KY32_ARB_LOCK_EN
  logic [$clog2(LOCK_MAX)-1:0] lcnt;
  logic                        keep;
  assign keep = lock[bus_sel] && req[bus_sel] && lcnt != ($clog2(LOCK_MAX))'(LOCK_MAX - 1);
`endif
  // Descending scan so the lowest offset after ptr wins; offset NREQ wraps back to ptr itself.
  function automatic logic [SELW-1:0] pick(input logic [NREQ-1:0] r, input logic [SELW-1:0] p);
    logic [SELW-1:0] w;
    w = p;
    for (int i = NREQ; i >= 1; i--)
      if (r[SELW'(p + SELW'(i))]) w = SELW'(p + SELW'(i));
    return w;
  endfunction
  assign win = pick(req, ptr);
  assign ack = gnt & {NREQ{bus_valid & bus_ready}};
  KY32_mux4x32 u_mux (.a0(d0), .a1(d1), .a2(d2), .a3(d3), .s(bus_sel), .y(bus_data));
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state     <= IDLE;
      gnt       <= '0;
      bus_sel   <= '0;
      bus_valid <= 1'b0;
      err       <= 1'b0;
      ptr       <= SELW'(NREQ - 1);
      cnt       <= '0;
`ifdef KY32_ARB_LOCK_EN
      lcnt      <= '0;
`endif
    end else begin
      err <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          state     <= BUSY;
          bus_sel   <= win;
          gnt       <= NREQ'(1) << win;
          bus_valid <= 1'b1;
          cnt       <= '0;
`ifdef KY32_ARB_LOCK_EN
          lcnt      <= '0;
`endif
        end
      end else if (bus_ready) begin
`ifdef KY32_ARB_LOCK_EN
        if (keep) begin
          cnt  <= '0;
          lcnt <= lcnt + 1'b1;
        end else
`endif
        begin
          state     <= IDLE;
          ptr       <= bus_sel;
          gnt       <= '0;
          bus_valid <= 1'b0;
        end
      end else if (TIMEOUT != 0 && cnt == TLIM) begin
        state     <= IDLE;
        ptr       <= bus_sel;
        gnt       <= '0;
        bus_valid <= 1'b0;
        err       <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: doc/ky32_bus_arbiter.md
Name: ky32_bus_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 32-bit downstream port (memory/bus slave) among four requesters.
- Drives the 2-bit select of a 4:1 32-bit mux, which carries the winning requester's word, and runs a valid/ready handshake with the slave.
- Returns a per-requester acknowledge when the transfer completes.
- Sits between the core's fetch/load-store/debug/DMA requesters and the shared memory port.

Parameters:
- TIMEOUT, 16, max cycles in BUSY waiting for bus_ready before forced release; 0 disables timeout.
- CW, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  clock, rising edge.
- clrn  input  1  asynchronous active-low reset.
- req  input  4  request per requester; held high until its ack.
- d0, d1, d2, d3  input  32 each  data/address word of requester 0..3.
- bus_data  output  32  muxed word of the granted requester.
- bus_sel  output  2  mux select; index of the granted requester.
- gnt  output  4  one-hot grant, registered.
- bus_valid  output  1  transfer valid to slave, registered.
- bus_ready  input  1  slave accepts transfer.
- ack  output  4  one-hot completion pulse, combinational: gnt & {4{bus_valid & bus_ready}}.
- err  output  1  one-cycle pulse on timeout release, registered.
- lock  input  4  keep-grant request per requester (only with KY32_ARB_LOCK_EN).

Behaviour:
- Reset (clrn=0, asynchronous): state=IDLE, gnt=0, bus_sel=0, bus_valid=0, err=0, ptr=3, timeout count=0. Requester 0 has first priority out of reset.
- bus_data is always the mux of d0..d3 by bus_sel. Its value is meaningful only while bus_valid=1.
- States: IDLE and BUSY.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner by scanning ptr+1, ptr+2, ptr+3, ptr (mod 4). The first requester with req=1 wins.
  - Next edge: gnt=onehot(winner), bus_sel=winner, bus_valid=1, count=0, state=BUSY.
  - Latency is 1 cycle from a sampled req to bus_valid.
- BUSY:
  - gnt, bus_sel and bus_valid are held stable.
  - If bus_ready=1: ack[winner]=1 in that cycle. Next edge: ptr=winner, gnt=0, bus_valid=0, state=IDLE.
  - Otherwise count increments.
  - If TIMEOUT!=0 and count reaches TIMEOUT-1 with bus_ready still 0: next edge sets err=1 for one cycle, ptr=winner, drops gnt and bus_valid, and returns to IDLE. No ack is issued.
- Minimum per-transfer cost is 2 cycles (IDLE+BUSY). No back-to-back grants without the lock feature.
- req deasserted during BUSY is a protocol violation. It is ignored and the transfer completes normally.
- req changes in IDLE take effect on the same edge they are sampled.
- bus_ready in IDLE is ignored; ack stays 0.
- bus_ready=1 on the same cycle as timeout expiry: ready wins. ack is issued and err stays 0.
- Fairness: a continuously requesting requester waits at most 3 other transfers.

Optional Feature:
- Macro: KY32_ARB_LOCK_EN.
- With the macro: lock port present. In BUSY with bus_ready=1 and lock[winner]=1 and req[winner]=1:
  - stay in BUSY with the same gnt/bus_sel and bus_valid=1 on the next cycle; ptr is not updated;
  - count clears;
  - the lock is held at most 4 consecutive transfers, then a forced release to IDLE with ptr=winner.
- Without the macro: no lock port; behaviour exactly as above.

Decomposition:
- Shared package ky32_arb_pkg: state encoding (IDLE=1'b0, BUSY=1'b1), NREQ=4, SELW=2, lock burst limit LOCK_MAX=4.
- Sub-module: the existing 4:1 32-bit mux (KY32_mux4x32), instantiated for bus_data with s=bus_sel.
- The round-robin priority pick is a combinational function inside the arbiter, not a separate module.

Test Plan:
- Reset then req=4'b0001, d0=32'hDEAD_BEEF, bus_ready=1 one cycle after valid → bus_valid at cycle 1, bus_sel=0, bus_data=DEADBEEF, ack=0001 coincident with ready, IDLE next.
- req=4'b1111 held, bus_ready=1 constantly → grant order 0,1,2,3,0; each ack 2 cycles apart; no requester granted twice in a row.
- Grant to 2 with bus_ready=0, TIMEOUT=16 → bus_valid held 16 cycles, err pulse 1 cycle, no ack, next grant goes to 3 if requesting.
- bus_ready rises on the exact expiry cycle → ack issued, err=0.
- clrn pulsed low mid-BUSY → gnt/bus_valid/err drop immediately without a clock; after release, req=1111 grants requester 0 first.
- (KY32_ARB_LOCK_EN) lock[1]=1, req=0011, ready=1 → four consecutive acks to 1 with bus_valid continuous, then forced IDLE, next grant to 0.
